// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: snake game sequencer with step timer, lives, pause, score and level
module game_flow_ctrl #(
  parameter int INIT_PERIOD      = 16,
  parameter int MIN_PERIOD       = 4,
  parameter int PERIOD_DEC       = 2,
  parameter int APPLES_PER_LEVEL = 5,
  parameter int LIVES            = 3,
  parameter int HEAD_LAT         = 1,
  parameter int SCORE_W          = 10,
  parameter int LEVEL_W          = 4
) (
  input  logic               clk2,
  input  logic               rst_n,
  input  logic               game_start_end,
  input  logic               pause_key,
  input  logic [1:0]         head,
  output logic               menu,
  output logic               first_do,
  output logic               go_one_step,
  output logic               eat_apple,
  output logic               random_growth,
  output logic               null_out,
  output logic               game_over,
  output logic               paused,
  output logic [3:0]         lives_left,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level,
  output logic [3:0]         state
);
  localparam int PW = $clog2(INIT_PERIOD + 1);
  localparam int CW = (HEAD_LAT > 1) ? $clog2(HEAD_LAT) : 1;
  localparam int AW = $clog2(APPLES_PER_LEVEL + 1);

  typedef enum logic [3:0] {
    S_MENU    = 4'd0,
    S_INIT    = 4'd1,
    S_WAIT    = 4'd2,
    S_STEP    = 4'd3,
    S_CHECK   = 4'd4,
    S_EAT     = 4'd5,
    S_GROW    = 4'd6,
    S_NULL    = 4'd7,
    S_HIT     = 4'd8,
    S_RESPAWN = 4'd9,
    S_PAUSE   = 4'd10,
    S_OVER    = 4'd11
  } state_t;

  state_t             r_state, w_next;
  logic               r_start_q, r_pause_q;
  logic               w_start_edge, w_pause_edge;
  logic [PW-1:0]      r_timer, r_period;
  logic [CW-1:0]      r_chk;
  logic [AW-1:0]      r_apples;
  logic [AW-1:0]      w_apples_nx;
  logic [SCORE_W-1:0] r_score;
  logic [LEVEL_W-1:0] r_level;
  logic [3:0]         r_lives;

  assign w_start_edge = game_start_end & ~r_start_q;
  assign w_pause_edge = pause_key & ~r_pause_q;
  assign w_apples_nx  = r_apples + AW'(1);

  // Key history; reset high so a key held through reset release gives no edge
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b1;
      r_pause_q <= 1'b1;
    end else begin
      r_start_q <= game_start_end;
      r_pause_q <= pause_key;
    end
  end

  // State register
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) r_state <= S_MENU;
    else        r_state <= w_next;
  end

  // Next-state logic; unused codes fall back to MENU
  always_comb begin
    w_next = S_MENU;
    case (r_state)
      S_MENU:    w_next = w_start_edge ? S_INIT : S_MENU;
      S_INIT:    w_next = S_WAIT;
      S_WAIT:    w_next = w_pause_edge ? S_PAUSE : (r_timer == '0 ? S_STEP : S_WAIT);
      S_PAUSE:   w_next = w_pause_edge ? S_WAIT : S_PAUSE;
      S_STEP:    w_next = S_CHECK;
      S_CHECK:   w_next = r_chk != '0 ? S_CHECK :
                          head == 2'b00 ? S_NULL :
                          head == 2'b10 ? S_EAT : S_HIT;
      S_NULL:    w_next = S_WAIT;
      S_EAT:     w_next = S_GROW;
      S_GROW:    w_next = S_WAIT;
      S_HIT:     w_next = r_lives > 4'd1 ? S_RESPAWN : S_OVER;
      S_RESPAWN: w_next = S_WAIT;
      S_OVER:    w_next = w_start_edge ? S_MENU : S_OVER;
      default:   w_next = S_MENU;
    endcase
  end

  // Game datapath: step timer, head-latency counter, score, level, period, lives
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      r_timer  <= '0;
      r_period <= PW'(INIT_PERIOD);
      r_chk    <= '0;
      r_apples <= '0;
      r_score  <= '0;
      r_level  <= '0;
      r_lives  <= 4'(LIVES);
    end else begin
      case (r_state)
        S_INIT: begin
          r_score  <= '0;
          r_level  <= '0;
          r_lives  <= 4'(LIVES);
          r_period <= PW'(INIT_PERIOD);
          r_apples <= '0;
          r_timer  <= PW'(INIT_PERIOD - 1);
        end
        S_WAIT:  if (!w_pause_edge && r_timer != '0) r_timer <= r_timer - PW'(1);
        S_STEP:  r_chk <= CW'(HEAD_LAT - 1);
        S_CHECK: if (r_chk != '0) r_chk <= r_chk - CW'(1);
        S_NULL, S_GROW, S_RESPAWN: r_timer <= r_period - PW'(1);
        S_EAT: begin
          if (r_score != '1) r_score <= r_score + SCORE_W'(1);
          if (w_apples_nx == AW'(APPLES_PER_LEVEL)) begin
            r_apples <= '0;
            if (r_level != '1) r_level <= r_level + LEVEL_W'(1);
            r_period <= (32'(r_period) >= 32'(MIN_PERIOD + PERIOD_DEC)) ?
                        r_period - PW'(PERIOD_DEC) : PW'(MIN_PERIOD);
          end else begin
            r_apples <= w_apples_nx;
          end
        end
        S_HIT: if (r_lives != '0) r_lives <= r_lives - 4'd1;
        default: ;
      endcase
    end
  end

  assign menu          = r_state == S_MENU;
  assign first_do      = r_state == S_INIT || r_state == S_RESPAWN;
  assign go_one_step   = r_state == S_STEP;
  assign eat_apple     = r_state == S_EAT;
  assign random_growth = r_state == S_GROW;
  assign null_out      = r_state == S_NULL;
  assign game_over     = r_state == S_OVER;
  assign paused        = r_state == S_PAUSE;
  assign lives_left    = r_lives;
  assign score         = r_score;
  assign level         = r_level;
  assign state         = r_state;
endmodule
